// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter in front of a single AR/R port, one transaction outstanding.
// R beats are routed to the granted master; an RLAST/ARLEN disagreement raises a one-cycle len_err_o.
module axi_rd_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int AR_W      = 49,
  parameter int R_W       = 39
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [AR_W-1:0] m0_ar_i,
  input  logic            m0_arvalid_i,
  output logic            m0_arready_o,
  output logic [R_W-1:0]  m0_r_o,
  output logic            m0_rvalid_o,
  input  logic            m0_rready_i,
  input  logic [AR_W-1:0] m1_ar_i,
  input  logic            m1_arvalid_i,
  output logic            m1_arready_o,
  output logic [R_W-1:0]  m1_r_o,
  output logic            m1_rvalid_o,
  input  logic            m1_rready_i,
  output logic [AR_W-1:0] s_ar_o,
  output logic            s_arvalid_o,
  input  logic            s_arready_i,
  input  logic [R_W-1:0]  s_r_i,
  input  logic            s_rvalid_i,
  output logic            s_rready_o,
  output logic [1:0]      gnt_o,
  output logic            len_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state, state_next;
  logic            gnt, gnt_next;
  logic            last_gnt, last_gnt_next;
  logic [7:0]      beat_cnt, beat_cnt_next;
  logic [7:0]      exp_len, exp_len_next;
  logic            len_err, len_err_next;

  logic            win;
  logic [AR_W-1:0] ar_sel;
  logic            arvalid_sel;
  logic            rready_sel;
  logic            rlast;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      beat_cnt <= 8'd0;
      exp_len  <= 8'd0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      last_gnt <= last_gnt_next;
      beat_cnt <= beat_cnt_next;
      exp_len  <= exp_len_next;
      len_err  <= len_err_next;
    end
  end

  always_comb begin
    ar_sel      = gnt ? m1_ar_i      : m0_ar_i;
    arvalid_sel = gnt ? m1_arvalid_i : m0_arvalid_i;
    rready_sel  = gnt ? m1_rready_i  : m0_rready_i;
    rlast       = s_r_i[0];

    // Winner is 1 for M1, 0 for M0; ties alternate away from the last grant in round-robin mode.
    if (PRIO_MODE != 0)
      win = m1_arvalid_i;
    else if (m0_arvalid_i && m1_arvalid_i)
      win = ~last_gnt;
    else
      win = m1_arvalid_i;
  end

  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    last_gnt_next = last_gnt;
    beat_cnt_next = beat_cnt;
    exp_len_next  = exp_len;
    len_err_next  = 1'b0;

    m0_arready_o  = 1'b0;
    m1_arready_o  = 1'b0;
    m0_r_o        = '0;
    m1_r_o        = '0;
    m0_rvalid_o   = 1'b0;
    m1_rvalid_o   = 1'b0;
    s_ar_o        = '0;
    s_arvalid_o   = 1'b0;
    s_rready_o    = 1'b0;

    case (state)
      IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          gnt_next      = win;
          last_gnt_next = win;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        s_ar_o       = ar_sel;
        s_arvalid_o  = arvalid_sel;
        m0_arready_o = ~gnt & s_arready_i;
        m1_arready_o = gnt & s_arready_i;
        if (arvalid_sel && s_arready_i) begin
          exp_len_next  = ar_sel[12:5];
          beat_cnt_next = 8'd0;
          state_next    = DATA;
        end
      end
      DATA: begin
        s_rready_o = rready_sel;
        if (gnt) begin
          m1_r_o      = s_r_i;
          m1_rvalid_o = s_rvalid_i;
        end else begin
          m0_r_o      = s_r_i;
          m0_rvalid_o = s_rvalid_i;
        end
        if (s_rvalid_i && rready_sel) begin
          beat_cnt_next = beat_cnt + 8'd1;
          // An early or late RLAST both flag; a late one keeps the burst running until RLAST.
          if (rlast) begin
            state_next   = IDLE;
            len_err_next = (beat_cnt != exp_len);
          end else begin
            len_err_next = (beat_cnt == exp_len);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_o     = (state == IDLE) ? 2'b00 : (gnt ? 2'b10 : 2'b01);
  assign len_err_o = len_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: round-robin instance and fixed-priority instance share stimulus,
// one held in reset while the other is exercised.
module tb_axi_rd_arbiter;

  localparam int AR_W = 49;
  localparam int R_W  = 39;

  logic            clk = 1'b0;
  logic            rst_rr_n, rst_fp_n;
  logic [AR_W-1:0] m0_ar, m1_ar;
  logic            m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic            s_arready, s_rvalid;
  logic [R_W-1:0]  s_r;

  logic            rr_m0_arready, rr_m0_rvalid, rr_m1_arready, rr_m1_rvalid;
  logic [R_W-1:0]  rr_m0_r, rr_m1_r;
  logic [AR_W-1:0] rr_s_ar;
  logic            rr_s_arvalid, rr_s_rready, rr_len_err;
  logic [1:0]      rr_gnt;

  logic            fp_m0_arready, fp_m0_rvalid, fp_m1_arready, fp_m1_rvalid;
  logic [R_W-1:0]  fp_m0_r, fp_m1_r;
  logic [AR_W-1:0] fp_s_ar;
  logic            fp_s_arvalid, fp_s_rready, fp_len_err;
  logic [1:0]      fp_gnt;

  // Observed outputs of whichever instance is under test.
  logic            sel;
  logic            o_m0_arready, o_m0_rvalid, o_m1_arready, o_m1_rvalid;
  logic [R_W-1:0]  o_m0_r, o_m1_r;
  logic [AR_W-1:0] o_s_ar;
  logic            o_s_arvalid, o_s_rready, o_len_err;
  logic [1:0]      o_gnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.PRIO_MODE(0), .AR_W(AR_W), .R_W(R_W)) u_rr (
    .clk_i(clk), .rst_n_i(rst_rr_n),
    .m0_ar_i(m0_ar), .m0_arvalid_i(m0_arvalid), .m0_arready_o(rr_m0_arready),
    .m0_r_o(rr_m0_r), .m0_rvalid_o(rr_m0_rvalid), .m0_rready_i(m0_rready),
    .m1_ar_i(m1_ar), .m1_arvalid_i(m1_arvalid), .m1_arready_o(rr_m1_arready),
    .m1_r_o(rr_m1_r), .m1_rvalid_o(rr_m1_rvalid), .m1_rready_i(m1_rready),
    .s_ar_o(rr_s_ar), .s_arvalid_o(rr_s_arvalid), .s_arready_i(s_arready),
    .s_r_i(s_r), .s_rvalid_i(s_rvalid), .s_rready_o(rr_s_rready),
    .gnt_o(rr_gnt), .len_err_o(rr_len_err)
  );

  axi_rd_arbiter #(.PRIO_MODE(1), .AR_W(AR_W), .R_W(R_W)) u_fp (
    .clk_i(clk), .rst_n_i(rst_fp_n),
    .m0_ar_i(m0_ar), .m0_arvalid_i(m0_arvalid), .m0_arready_o(fp_m0_arready),
    .m0_r_o(fp_m0_r), .m0_rvalid_o(fp_m0_rvalid), .m0_rready_i(m0_rready),
    .m1_ar_i(m1_ar), .m1_arvalid_i(m1_arvalid), .m1_arready_o(fp_m1_arready),
    .m1_r_o(fp_m1_r), .m1_rvalid_o(fp_m1_rvalid), .m1_rready_i(m1_rready),
    .s_ar_o(fp_s_ar), .s_arvalid_o(fp_s_arvalid), .s_arready_i(s_arready),
    .s_r_i(s_r), .s_rvalid_i(s_rvalid), .s_rready_o(fp_s_rready),
    .gnt_o(fp_gnt), .len_err_o(fp_len_err)
  );

  assign o_m0_arready = sel ? fp_m0_arready : rr_m0_arready;
  assign o_m1_arready = sel ? fp_m1_arready : rr_m1_arready;
  assign o_m0_rvalid  = sel ? fp_m0_rvalid  : rr_m0_rvalid;
  assign o_m1_rvalid  = sel ? fp_m1_rvalid  : rr_m1_rvalid;
  assign o_m0_r       = sel ? fp_m0_r       : rr_m0_r;
  assign o_m1_r       = sel ? fp_m1_r       : rr_m1_r;
  assign o_s_ar       = sel ? fp_s_ar       : rr_s_ar;
  assign o_s_arvalid  = sel ? fp_s_arvalid  : rr_s_arvalid;
  assign o_s_rready   = sel ? fp_s_rready   : rr_s_rready;
  assign o_len_err    = sel ? fp_len_err    : rr_len_err;
  assign o_gnt        = sel ? fp_gnt        : rr_gnt;

  function automatic logic [AR_W-1:0] mk_ar(input logic [3:0] id, input logic [31:0] addr,
                                            input logic [7:0] len);
    return {id, addr, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [31:0] data, input logic [1:0] resp,
                                          input logic last);
    return {4'h0, data, resp, last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in IDLE with the request already raised; leaves at a negedge in DATA.
  task automatic addr_phase(input logic who, input logic [AR_W-1:0] ar);
    @(negedge clk);
    chk("gnt_addr", 64'(o_gnt), who ? 64'd2 : 64'd1);
    chk("s_arvalid", 64'(o_s_arvalid), 64'd1);
    chk("s_ar", 64'(o_s_ar), 64'(ar));
    s_arready = 1'b1;
    #1;
    chk("arready_win", 64'(who ? o_m1_arready : o_m0_arready), 64'd1);
    chk("arready_lose", 64'(who ? o_m0_arready : o_m1_arready), 64'd0);
    @(negedge clk);
    s_arready = 1'b0;
    if (who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
  endtask

  // Presents one slave beat for a cycle; leaves at the next negedge with the beat removed.
  task automatic beat(input logic who, input logic [R_W-1:0] r, input logic rdy);
    s_r = r;
    s_rvalid = 1'b1;
    if (who) m1_rready = rdy; else m0_rready = rdy;
    #1;
    chk("rvalid_win", 64'(who ? o_m1_rvalid : o_m0_rvalid), 64'd1);
    chk("rvalid_lose", 64'(who ? o_m0_rvalid : o_m1_rvalid), 64'd0);
    chk("r_payload", 64'(who ? o_m1_r : o_m0_r), 64'(r));
    chk("s_rready", 64'(o_s_rready), 64'(rdy));
    @(negedge clk);
    s_rvalid = 1'b0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    rst_rr_n = 1'b0; rst_fp_n = 1'b0;
    m0_ar = '0; m1_ar = '0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_s_arvalid", 64'(o_s_arvalid), 64'd0);
    chk("rst_s_rready", 64'(o_s_rready), 64'd0);
    chk("rst_len_err", 64'(o_len_err), 64'd0);
    rst_rr_n = 1'b1;

    // Single M0 read, arlen 0.
    @(negedge clk);
    m0_ar = mk_ar(4'h1, 32'h8000_0004, 8'd0);
    m0_arvalid = 1'b1;
    #1;
    chk("idle_arready", 64'(o_m0_arready), 64'd0);
    chk("idle_gnt", 64'(o_gnt), 64'd0);
    addr_phase(1'b0, mk_ar(4'h1, 32'h8000_0004, 8'd0));
    beat(1'b0, mk_r(32'h1234_5678, 2'b00, 1'b1), 1'b1);
    chk("single_gnt_idle", 64'(o_gnt), 64'd0);
    chk("single_len_err", 64'(o_len_err), 64'd0);

    // Round-robin ties from reset: M0, M1, M0, M1.
    rst_rr_n = 1'b0;
    @(negedge clk);
    rst_rr_n = 1'b1;
    m0_ar = mk_ar(4'h2, 32'h0000_1000, 8'd0);
    m1_ar = mk_ar(4'h3, 32'h0000_2000, 8'd0);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    addr_phase(1'b0, mk_ar(4'h2, 32'h0000_1000, 8'd0));
    beat(1'b0, mk_r(32'hA0A0_0001, 2'b00, 1'b1), 1'b1);
    addr_phase(1'b1, mk_ar(4'h3, 32'h0000_2000, 8'd0));
    beat(1'b1, mk_r(32'hB0B0_0002, 2'b00, 1'b1), 1'b1);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    addr_phase(1'b0, mk_ar(4'h2, 32'h0000_1000, 8'd0));
    beat(1'b0, mk_r(32'hA0A0_0003, 2'b10, 1'b1), 1'b1);
    addr_phase(1'b1, mk_ar(4'h3, 32'h0000_2000, 8'd0));
    beat(1'b1, mk_r(32'hB0B0_0004, 2'b11, 1'b1), 1'b1);
    chk("tie_len_err", 64'(o_len_err), 64'd0);

    // Burst arlen 3 to M1 with one stalled beat.
    m1_ar = mk_ar(4'h4, 32'h0000_3000, 8'd3);
    m1_arvalid = 1'b1;
    addr_phase(1'b1, mk_ar(4'h4, 32'h0000_3000, 8'd3));
    beat(1'b1, mk_r(32'hC000_0000, 2'b00, 1'b0), 1'b1);
    beat(1'b1, mk_r(32'hC000_0001, 2'b00, 1'b0), 1'b0);
    beat(1'b1, mk_r(32'hC000_0001, 2'b00, 1'b0), 1'b1);
    beat(1'b1, mk_r(32'hC000_0002, 2'b00, 1'b0), 1'b1);
    chk("burst_mid_gnt", 64'(o_gnt), 64'd2);
    beat(1'b1, mk_r(32'hC000_0003, 2'b00, 1'b1), 1'b1);
    chk("burst_gnt_idle", 64'(o_gnt), 64'd0);
    chk("burst_len_err", 64'(o_len_err), 64'd0);

    // Early RLAST on the second beat of a 4-beat burst.
    m0_ar = mk_ar(4'h5, 32'h0000_4000, 8'd3);
    m0_arvalid = 1'b1;
    addr_phase(1'b0, mk_ar(4'h5, 32'h0000_4000, 8'd3));
    beat(1'b0, mk_r(32'hD000_0000, 2'b00, 1'b0), 1'b1);
    chk("lenerr_pre", 64'(o_len_err), 64'd0);
    beat(1'b0, mk_r(32'hD000_0001, 2'b00, 1'b1), 1'b1);
    chk("lenerr_pulse", 64'(o_len_err), 64'd1);
    chk("lenerr_gnt_idle", 64'(o_gnt), 64'd0);
    @(negedge clk);
    chk("lenerr_clear", 64'(o_len_err), 64'd0);

    // Async reset in DATA after beat 1 of 4, then a fresh M1 request.
    m0_ar = mk_ar(4'h6, 32'h0000_5000, 8'd3);
    m0_arvalid = 1'b1;
    addr_phase(1'b0, mk_ar(4'h6, 32'h0000_5000, 8'd3));
    beat(1'b0, mk_r(32'hE000_0000, 2'b00, 1'b0), 1'b1);
    s_r = mk_r(32'hE000_0001, 2'b00, 1'b0);
    s_rvalid = 1'b1;
    m0_rready = 1'b1;
    #2;
    rst_rr_n = 1'b0;
    #1;
    chk("arst_gnt", 64'(o_gnt), 64'd0);
    chk("arst_rvalid", 64'(o_m0_rvalid), 64'd0);
    chk("arst_s_rready", 64'(o_s_rready), 64'd0);
    chk("arst_s_arvalid", 64'(o_s_arvalid), 64'd0);
    @(negedge clk);
    s_rvalid = 1'b0; m0_rready = 1'b0;
    rst_rr_n = 1'b1;
    m1_ar = mk_ar(4'h7, 32'h0000_6000, 8'd0);
    m1_arvalid = 1'b1;
    addr_phase(1'b1, mk_ar(4'h7, 32'h0000_6000, 8'd0));
    beat(1'b1, mk_r(32'hF000_0000, 2'b00, 1'b1), 1'b1);
    chk("arst_after_len_err", 64'(o_len_err), 64'd0);

    // Fixed priority instance: M1 wins ties and keeps winning on re-request.
    rst_rr_n = 1'b0;
    sel = 1'b1;
    rst_fp_n = 1'b1;
    m0_ar = mk_ar(4'h8, 32'h0000_7000, 8'd0);
    m1_ar = mk_ar(4'h9, 32'h0000_8000, 8'd0);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    addr_phase(1'b1, mk_ar(4'h9, 32'h0000_8000, 8'd0));
    m1_ar = mk_ar(4'hA, 32'h0000_9000, 8'd0);
    m1_arvalid = 1'b1;
    beat(1'b1, mk_r(32'h1111_0000, 2'b00, 1'b1), 1'b1);
    addr_phase(1'b1, mk_ar(4'hA, 32'h0000_9000, 8'd0));
    beat(1'b1, mk_r(32'h1111_0001, 2'b00, 1'b1), 1'b1);
    addr_phase(1'b0, mk_ar(4'h8, 32'h0000_7000, 8'd0));
    beat(1'b0, mk_r(32'h2222_0000, 2'b00, 1'b1), 1'b1);
    chk("fp_gnt_idle", 64'(o_gnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
